// File: rtl/system_types_pkg.sv
// rtl/system_types_pkg.sv - shared widths, PTE layout and page-table-walker types
package system_types_pkg;

    localparam int VPN_WIDTH    = 20;
    localparam int PPN_WIDTH    = 22;
    localparam int PA_WIDTH     = 34;
    localparam int PTE_SIZE     = 4;
    localparam int LOG_PTE_SIZE = 2;

    localparam logic PTW_REQUESTER_ITLB = 1'b0;
    localparam logic PTW_REQUESTER_DTLB = 1'b1;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        RESP,
        DRAIN
    } ptw_state_t;

endpackage

// File: rtl/sv32_pte_checker.sv
// rtl/sv32_pte_checker.sv - combinational Sv32 PTE validity/leaf classification
module sv32_pte_checker
    import system_types_pkg::*;
(
    input  pte_t pte,
    input  logic level,
    output logic fault,
    output logic leaf,
    output logic superpage
);

    logic invalid;
    logic is_leaf;
    logic misaligned;
    logic unused_bits;

    assign unused_bits = ^{pte.ppn1, pte.rsw, pte.d, pte.g, pte.u};

    always_comb begin
        invalid    = !pte.v || (pte.w && !pte.r);
        is_leaf    = pte.r || pte.x;
        // A level-1 leaf must map a 4MB-aligned frame, so its low PPN must be zero.
        misaligned = level && (pte.ppn0 != '0);
        fault      = invalid
                   || (is_leaf && (!pte.a || misaligned))
                   || (!level && !is_leaf);
        leaf       = is_leaf && !invalid;
        superpage  = level && leaf && !fault;
    end

endmodule

// File: rtl/sv32_ptw.sv
// rtl/sv32_ptw.sv - Sv32 two-level page table walker shared by ITLB and DTLB
module sv32_ptw
    import system_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [PPN_WIDTH-1:0] satp_PPN,
    input  logic                 flush_valid,
    input  logic                 itlb_req_valid,
    input  logic [VPN_WIDTH-1:0] itlb_req_VPN,
    output logic                 itlb_req_ready,
    input  logic                 dtlb_req_valid,
    input  logic [VPN_WIDTH-1:0] dtlb_req_VPN,
    output logic                 dtlb_req_ready,
    output logic                 mem_req_valid,
    output logic [PA_WIDTH-1:0]  mem_req_PA,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  pte_t                 mem_resp_pte,
    output logic                 resp_valid,
    output logic                 resp_requester,
    output logic [VPN_WIDTH-1:0] resp_VPN,
    output pte_t                 resp_pte,
    output logic                 resp_superpage,
    output logic                 resp_page_fault
);

    ptw_state_t           state;
    ptw_state_t           next_state;
    logic                 req_q;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic [PPN_WIDTH-1:0] root_q;
    pte_t                 pte_q;
    logic                 sp_q;
    logic                 fault_q;
    logic                 rr_last;

    logic                 grant_any;
    logic                 grant_sel;
    logic                 chk_level;
    logic                 chk_fault;
    logic                 chk_leaf;
    logic                 chk_sp;

    assign chk_level = (state == L1_WAIT);

    sv32_pte_checker u_checker (
        .pte       (mem_resp_pte),
        .level     (chk_level),
        .fault     (chk_fault),
        .leaf      (chk_leaf),
        .superpage (chk_sp)
    );

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grant_sel = dtlb_req_valid ? PTW_REQUESTER_DTLB : PTW_REQUESTER_ITLB;
        if (itlb_req_valid && dtlb_req_valid) begin
            grant_sel = ~rr_last;
        end
        grant_any      = (state == IDLE) && !flush_valid && (itlb_req_valid || dtlb_req_valid);
        itlb_req_ready = grant_any && (grant_sel == PTW_REQUESTER_ITLB);
        dtlb_req_ready = grant_any && (grant_sel == PTW_REQUESTER_DTLB);
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_PA    = '0;
        if (state == L1_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_PA    = {root_q, vpn_q[19:10], {LOG_PTE_SIZE{1'b0}}};
        end else if (state == L0_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_PA    = {pte_q.ppn1, pte_q.ppn0, vpn_q[9:0], {LOG_PTE_SIZE{1'b0}}};
        end
    end

    always_comb begin
        resp_valid      = (state == RESP) && !flush_valid;
        resp_requester  = resp_valid ? req_q : 1'b0;
        resp_VPN        = resp_valid ? vpn_q : '0;
        resp_pte        = resp_valid ? pte_q : '0;
        resp_superpage  = resp_valid ? sp_q : 1'b0;
        resp_page_fault = resp_valid ? fault_q : 1'b0;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_any) next_state = L1_REQ;
            end
            L1_REQ, L0_REQ: begin
                // A request already handed to memory must have its data drained.
                if (mem_req_ready) begin
                    if (flush_valid)          next_state = DRAIN;
                    else if (state == L1_REQ) next_state = L1_WAIT;
                    else                      next_state = L0_WAIT;
                end else if (flush_valid) begin
                    next_state = IDLE;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (mem_resp_valid) begin
                    if (flush_valid)                next_state = IDLE;
                    else if (chk_fault || chk_leaf) next_state = RESP;
                    else                            next_state = L0_REQ;
                end else if (flush_valid) begin
                    next_state = DRAIN;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            DRAIN: begin
                if (mem_resp_valid) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            req_q   <= PTW_REQUESTER_ITLB;
            vpn_q   <= '0;
            root_q  <= '0;
            pte_q   <= '0;
            sp_q    <= 1'b0;
            fault_q <= 1'b0;
            rr_last <= PTW_REQUESTER_DTLB;
        end else begin
            state <= next_state;
            if ((state == IDLE) && grant_any) begin
                req_q  <= grant_sel;
                vpn_q  <= (grant_sel == PTW_REQUESTER_DTLB) ? dtlb_req_VPN : itlb_req_VPN;
                root_q <= satp_PPN;
            end
            if (((state == L1_WAIT) || (state == L0_WAIT)) && mem_resp_valid) begin
                pte_q   <= mem_resp_pte;
                sp_q    <= chk_sp;
                fault_q <= chk_fault;
            end
            if (state == RESP) begin
                rr_last <= req_q;
            end
        end
    end

endmodule
